id_ex_pipeline_register: RTL and testbench
==========================================

Name: id_ex_pipeline_register

Overview:
- Pipeline register between the Decode stage (register file read, immediate generation, control unit) and the Execute stage of the 5-stage RV32I pipelined CPU.
- Captures decoded operands, the sign-extended immediate, register indices and control bits each cycle.
- Inserts bubbles on load-use stalls, holds contents on downstream back-pressure, and enforces a sticky halt drain once an ECALL-halt instruction is latched.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
REG_ADDR_W, 5, register index width
CNT_W, 32, width of the optional performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_valid  input  1  Decode stage holds a real instruction
id_bubble  input  1  hazard unit requests bubble insertion (load-use)
ex_hold  input  1  Execute stage cannot accept; freeze register contents
id_pc  input  XLEN  PC of decoded instruction
id_rs1_data  input  XLEN  register file read port 1
id_rs2_data  input  XLEN  register file read port 2
id_imm  input  XLEN  sign-extended immediate from immediate generator
id_rs1  input  REG_ADDR_W  source index 1
id_rs2  input  REG_ADDR_W  source index 2
id_rd  input  REG_ADDR_W  destination index
id_alu_ctrl  input  4  ALU operation select ({funct7[5], funct3})
id_alu_src  input  1  1 = ALU operand B is immediate
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  writeback from memory
id_reg_write  input  1  writes rd
id_is_halted  input  1  instruction is ECALL with x17 == 10
ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_is_halted  output  (widths as id_ counterparts)  registered copies
halt_latched  output  1  sticky: a halting instruction has entered Execute
bubble_cnt  output  CNT_W  bubbles inserted (optional feature)
issue_cnt  output  CNT_W  valid instructions issued (optional feature)

Behaviour:
- Reset (synchronous, highest priority): every output, including halt_latched and both counters, is 0; state = RUN.
- States:
  - RUN: normal capture.
  - DRAIN: a halt was latched; no further instructions are accepted.
  - RUN -> DRAIN on the edge that captures a valid instruction with id_is_halted = 1.
  - DRAIN is left only by reset.
- Per-edge priority when not in reset:
  1. ex_hold = 1: all ex_* hold; counters unchanged. ex_hold overrides id_bubble.
  2. State DRAIN, id_bubble = 1, or id_valid = 0: load a bubble. All ex_* fields are 0, including ex_valid, control bits, data, indices and ex_is_halted. bubble_cnt increments only when id_bubble = 1 and state = RUN.
  3. Otherwise: capture all id_* fields; ex_valid = 1; issue_cnt increments.
- x0 rule: on capture, ex_reg_write = id_reg_write AND (id_rd != 0). ex_rd is still copied verbatim.
- Consistency rule: on capture, if id_mem_write = 1, then ex_reg_write = 0 and ex_mem_to_reg = 0, whatever the inputs.
- halt_latched = 1 in DRAIN, 0 in RUN. It asserts on the same edge ex_is_halted first becomes 1.
- Latency: exactly 1 cycle from id_* to ex_*. Nothing combinational passes from id_* to ex_*.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-hold or in DRAIN: the next edge gives reset values regardless of ex_hold.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: bubble_cnt and issue_cnt are implemented as specified.
- Undefined: the counter registers are not instantiated; bubble_cnt and issue_cnt are tied to constant 0. The ports stay present so instantiations are identical in both builds.

Test Plan:
- Reset for 2 cycles, then release with id_valid = 0 -> all ex_* = 0, ex_valid = 0, halt_latched = 0, counters = 0.
- Capture: id_pc = 0x00000010, id_imm = 0xFFFFF800, id_rd = 5, id_reg_write = 1 -> next cycle ex_pc = 0x10, ex_imm = 0xFFFFF800, ex_reg_write = 1, ex_valid = 1, issue_cnt = 1.
- x0 and store rules: id_rd = 0 with id_reg_write = 1 -> ex_reg_write = 0. id_mem_write = 1 with id_reg_write = 1 and id_mem_to_reg = 1 -> ex_reg_write = 0, ex_mem_to_reg = 0, ex_mem_write = 1.
- Load-use: id_bubble = 1 for 1 cycle with a valid instruction present -> one cycle of ex_valid = 0 with all controls 0; bubble_cnt = 1; issue_cnt unchanged.
- Hold priority: ex_hold = 1 and id_bubble = 1 for 3 cycles after capturing pc 0x20 -> ex_pc stays 0x20, ex_valid stays 1, counters unchanged.
- Halt drain: capture id_is_halted = 1 at pc 0x40, then feed valid instructions at pc 0x44 and 0x48.
  - Cycle after capture: halt_latched = 1, ex_is_halted = 1.
  - Following cycles: bubbles only.
  - Assert reset -> RUN state, halt_latched = 0.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// ============================================================================
// Module   : id_ex_pipeline_register
// Purpose  : ID->EX pipeline register with bubble insertion, hold and sticky halt drain.
//            Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipeline_register #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_bubble,
  input  logic                  ex_hold,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  id_is_halted,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            ex_alu_ctrl,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_is_halted,
  output logic                  halt_latched,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      issue_cnt
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    halt_q;
  logic                    valid_q;
  logic [XLEN-1:0]         pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REG_ADDR_W-1:0]   rs1_q, rs2_q, rd_q;
  logic [3:0]              alu_ctrl_q;
  logic                    alu_src_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q, is_halted_q;

  logic                    load_bubble_d;
  logic                    reg_write_d;
  logic                    mem_to_reg_d;

  assign load_bubble_d = (state_q == DRAIN) || id_bubble || !id_valid;
  // Writes to x0 are discarded, and a store never writes back.
  assign reg_write_d   = id_reg_write && (id_rd != '0) && !id_mem_write;
  assign mem_to_reg_d  = id_mem_to_reg && !id_mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      halt_q       <= 1'b0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      is_halted_q  <= 1'b0;
    end else if (!ex_hold) begin
      if (load_bubble_d) begin
        valid_q      <= 1'b0;
        pc_q         <= '0;
        rs1_data_q   <= '0;
        rs2_data_q   <= '0;
        imm_q        <= '0;
        rs1_q        <= '0;
        rs2_q        <= '0;
        rd_q         <= '0;
        alu_ctrl_q   <= '0;
        alu_src_q    <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
        reg_write_q  <= 1'b0;
        is_halted_q  <= 1'b0;
      end else begin
        valid_q      <= 1'b1;
        pc_q         <= id_pc;
        rs1_data_q   <= id_rs1_data;
        rs2_data_q   <= id_rs2_data;
        imm_q        <= id_imm;
        rs1_q        <= id_rs1;
        rs2_q        <= id_rs2;
        rd_q         <= id_rd;
        alu_ctrl_q   <= id_alu_ctrl;
        alu_src_q    <= id_alu_src;
        mem_read_q   <= id_mem_read;
        mem_write_q  <= id_mem_write;
        mem_to_reg_q <= mem_to_reg_d;
        reg_write_q  <= reg_write_d;
        is_halted_q  <= id_is_halted;
        // Halt is sticky: only reset returns the stage to RUN.
        if (id_is_halted) begin
          state_q <= DRAIN;
          halt_q  <= 1'b1;
        end
      end
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_is_halted  = is_halted_q;
  assign halt_latched  = halt_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] issue_cnt_q;

  // Bubbles forced by DRAIN or an empty decode slot are not load-use bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      issue_cnt_q  <= '0;
    end else if (!ex_hold) begin
      if (load_bubble_d) begin
        if (id_bubble && (state_q == RUN)) begin
          bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign issue_cnt  = issue_cnt_q;
`else
  assign bubble_cnt = '0;
  assign issue_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipeline_register.sv
// ============================================================================
// Module   : tb_id_ex_pipeline_register
// Purpose  : Directed plus randomized check of id_ex_pipeline_register against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipeline_register;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_bubble, ex_hold;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_is_halted;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_is_halted;
  logic        halt_latched;
  logic [31:0] bubble_cnt, issue_cnt;

  id_ex_pipeline_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_bubble(id_bubble), .ex_hold(ex_hold),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_is_halted(id_is_halted),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_is_halted(ex_is_halted),
    .halt_latched(halt_latched), .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the expected contents of the Execute slot as a flat record.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src, mem_read, mem_write, mem_to_reg, reg_write, is_halted;
  } slot_t;

  slot_t       m_slot;
  slot_t       empty_slot;
  bit          m_halted;
  int unsigned m_bubbles, m_issued;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Applies one clock edge worth of rules to the model, using the inputs seen at that edge.
  function automatic void model_edge();
    slot_t s;
    if (reset) begin
      m_slot = empty_slot; m_halted = 0; m_bubbles = 0; m_issued = 0;
    end else if (ex_hold) begin
      // nothing moves
    end else if (m_halted || id_bubble || !id_valid) begin
      if (id_bubble && !m_halted) m_bubbles++;
      m_slot = empty_slot;
    end else begin
      s.valid = 1; s.pc = id_pc; s.rs1_data = id_rs1_data; s.rs2_data = id_rs2_data;
      s.imm = id_imm; s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd; s.alu_ctrl = id_alu_ctrl;
      s.alu_src = id_alu_src; s.mem_read = id_mem_read; s.mem_write = id_mem_write;
      s.mem_to_reg = id_mem_write ? 1'b0 : id_mem_to_reg;
      s.reg_write  = (id_mem_write || id_rd == 5'd0) ? 1'b0 : id_reg_write;
      s.is_halted = id_is_halted;
      m_slot = s;
      m_issued++;
      if (id_is_halted) m_halted = 1;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"},      32'(ex_valid),      32'(m_slot.valid));
    check({tag, ".pc"},         ex_pc,              m_slot.pc);
    check({tag, ".rs1_data"},   ex_rs1_data,        m_slot.rs1_data);
    check({tag, ".rs2_data"},   ex_rs2_data,        m_slot.rs2_data);
    check({tag, ".imm"},        ex_imm,             m_slot.imm);
    check({tag, ".rs1"},        32'(ex_rs1),        32'(m_slot.rs1));
    check({tag, ".rs2"},        32'(ex_rs2),        32'(m_slot.rs2));
    check({tag, ".rd"},         32'(ex_rd),         32'(m_slot.rd));
    check({tag, ".alu_ctrl"},   32'(ex_alu_ctrl),   32'(m_slot.alu_ctrl));
    check({tag, ".alu_src"},    32'(ex_alu_src),    32'(m_slot.alu_src));
    check({tag, ".mem_read"},   32'(ex_mem_read),   32'(m_slot.mem_read));
    check({tag, ".mem_write"},  32'(ex_mem_write),  32'(m_slot.mem_write));
    check({tag, ".mem_to_reg"}, 32'(ex_mem_to_reg), 32'(m_slot.mem_to_reg));
    check({tag, ".reg_write"},  32'(ex_reg_write),  32'(m_slot.reg_write));
    check({tag, ".is_halted"},  32'(ex_is_halted),  32'(m_slot.is_halted));
    check({tag, ".halt_latched"}, 32'(halt_latched), 32'(m_halted));
    check({tag, ".bubble_cnt"}, bubble_cnt, PERF ? m_bubbles : 32'd0);
    check({tag, ".issue_cnt"},  issue_cnt,  PERF ? m_issued  : 32'd0);
  endtask

  // One clock: model sees the same inputs as the DUT edge, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    reset = 0; id_valid = 0; id_bubble = 0; ex_hold = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_reg_write = 0; id_is_halted = 0;
  endtask

  initial begin
    empty_slot = '{valid: 0, pc: 0, rs1_data: 0, rs2_data: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
                   alu_ctrl: 0, alu_src: 0, mem_read: 0, mem_write: 0, mem_to_reg: 0,
                   reg_write: 0, is_halted: 0};
    m_slot = empty_slot; m_halted = 0; m_bubbles = 0; m_issued = 0;
    clear_inputs();

    // Reset for two cycles, then release with an empty decode slot.
    reset = 1;
    step("rst0");
    step("rst1");
    reset = 0;
    step("idle");
    check("idle_valid", 32'(ex_valid), 32'd0);
    check("idle_halt", 32'(halt_latched), 32'd0);

    // Plain capture.
    id_valid = 1; id_pc = 32'h10; id_imm = 32'hFFFF_F800; id_rd = 5'd5; id_reg_write = 1;
    id_rs1_data = 32'h1234_5678; id_rs2_data = 32'h9ABC_DEF0; id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_alu_ctrl = 4'b1000; id_alu_src = 1;
    step("cap");
    check("cap_pc", ex_pc, 32'h10);
    check("cap_imm", ex_imm, 32'hFFFF_F800);
    check("cap_regwr", 32'(ex_reg_write), 32'd1);
    check("cap_issue", issue_cnt, PERF ? 32'd1 : 32'd0);

    // Write to x0 is suppressed, rd still copied.
    id_pc = 32'h14; id_rd = 5'd0;
    step("x0");
    check("x0_regwr", 32'(ex_reg_write), 32'd0);

    // Store clears writeback controls.
    id_pc = 32'h18; id_rd = 5'd7; id_mem_write = 1; id_mem_to_reg = 1;
    step("store");
    check("st_regwr", 32'(ex_reg_write), 32'd0);
    check("st_m2r", 32'(ex_mem_to_reg), 32'd0);
    check("st_memwr", 32'(ex_mem_write), 32'd1);
    id_mem_write = 0; id_mem_to_reg = 0;

    // Load-use bubble with a valid instruction present.
    id_pc = 32'h1C; id_bubble = 1;
    step("bubble");
    check("bub_valid", 32'(ex_valid), 32'd0);
    check("bub_cnt", bubble_cnt, PERF ? 32'd1 : 32'd0);
    id_bubble = 0;

    // Capture pc 0x20, then hold with a bubble request for three cycles.
    id_pc = 32'h20;
    step("cap20");
    ex_hold = 1; id_bubble = 1; id_pc = 32'h24;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold_pc", ex_pc, 32'h20);
    end
    ex_hold = 0; id_bubble = 0;

    // Halt instruction followed by two more valid instructions.
    id_pc = 32'h40; id_is_halted = 1;
    step("halt");
    check("halt_latched", 32'(halt_latched), 32'd1);
    check("halt_ex", 32'(ex_is_halted), 32'd1);
    id_is_halted = 0; id_pc = 32'h44;
    step("drain44");
    id_pc = 32'h48; id_bubble = 1;
    step("drain48");
    check("drain_valid", 32'(ex_valid), 32'd0);
    id_bubble = 0;

    // Reset during hold while draining still wins.
    reset = 1; ex_hold = 1;
    step("rst_drain");
    check("rst_halt", 32'(halt_latched), 32'd0);
    reset = 0; ex_hold = 0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 39) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_bubble    = ($urandom_range(0, 4) == 0);
      ex_hold      = ($urandom_range(0, 5) == 0);
      id_is_halted = ($urandom_range(0, 24) == 0);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom);
      id_rs2       = 5'($urandom);
      id_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      id_alu_ctrl  = 4'($urandom);
      id_alu_src   = 1'($urandom);
      id_mem_read  = 1'($urandom);
      id_mem_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_reg_write = 1'($urandom);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
